// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bit-serial two-operand logic unit.
// A start in IDLE latches a, b and mode, then one lane per clock is computed
// LSB first through a nor-only gate network and written into s. eq tracks
// whether every processed lane of a and b agreed. done pulses for one cycle
// after the last lane, and the block then returns to IDLE.
module serial_logic_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             eq,
   output logic             busy,
   output logic             done
);

   // Lane index is at least one bit wide so WIDTH=1 still has a legal counter.
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       mode_q;
   logic [IDX_W-1:0] idx;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] lane_mask;
   logic             lane_a;
   logic             lane_b;
   logic             last_lane;

   // Current lane operands and the one-hot write mask for s.
   assign a_sh      = a_q >> idx;
   assign b_sh      = b_q >> idx;
   assign lane_a    = a_sh[0];
   assign lane_b    = b_sh[0];
   assign lane_mask = WIDTH'(1) << idx;
   assign last_lane = (idx == LAST_IDX);

   // ------------------------------------------------------------------
   // Per-lane gate network, nor primitives only.
   //   r0 = XNOR, r1 = XOR, r2 = NOR, r3 = NAND of (lane_a, lane_b)
   // The complement of each candidate is already available in the network,
   // which lets each 2:1 mux be two nors plus one combining nor.
   // ------------------------------------------------------------------
   wire n_or;       // ~(a|b)      : r2
   wire n_a;        // ~a
   wire n_b;        // ~b
   wire and_v;      // a&b         : ~r3
   wire or_v;       // a|b         : ~r2
   wire nand_v;     // ~(a&b)      : r3
   wire xor_v;      // a^b         : r1, ~r0
   wire xnor_v;     // ~(a^b)      : r0, ~r1
   wire n_m0;
   wire n_m1;
   wire lo_a, lo_b, lo_n;
   wire hi_a, hi_b, hi_n;
   wire out_a, out_b, lane_n, lane_bit;

   nor u_nor_ab  (n_or,   lane_a, lane_b);
   nor u_inv_a   (n_a,    lane_a, lane_a);
   nor u_inv_b   (n_b,    lane_b, lane_b);
   nor u_and     (and_v,  n_a,    n_b);
   nor u_or      (or_v,   n_or,   n_or);
   nor u_nand    (nand_v, and_v,  and_v);
   nor u_xor     (xor_v,  and_v,  n_or);
   nor u_xnor    (xnor_v, xor_v,  xor_v);

   nor u_inv_m0  (n_m0,   mode_q[0], mode_q[0]);
   nor u_inv_m1  (n_m1,   mode_q[1], mode_q[1]);

   // mode[0] picks XNOR/XOR (low pair) and NOR/NAND (high pair).
   nor u_lo_a    (lo_a,   xor_v,  mode_q[0]);   // xnor & ~m0
   nor u_lo_b    (lo_b,   xnor_v, n_m0);        // xor  &  m0
   nor u_lo_n    (lo_n,   lo_a,   lo_b);        // ~low pair result
   nor u_hi_a    (hi_a,   or_v,   mode_q[0]);   // nor  & ~m0
   nor u_hi_b    (hi_b,   and_v,  n_m0);        // nand &  m0
   nor u_hi_n    (hi_n,   hi_a,   hi_b);        // ~high pair result

   // mode[1] picks between the pairs.
   nor u_out_a   (out_a,  lo_n,   mode_q[1]);
   nor u_out_b   (out_b,  hi_n,   n_m1);
   nor u_lane_n  (lane_n, out_a,  out_b);
   nor u_lane    (lane_bit, lane_n, lane_n);

   // State register; reset wins over everything.
   always_ff @(posedge clk) begin
      // NOTE: every register in a clocked block uses <= so all of them update
      // from the same pre-edge values regardless of statement order.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: assigning the default first guarantees no path leaves
      // state_next unassigned, so no latch is inferred.
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_lane) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand latch, lane index, result and equality flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         mode_q <= 2'b00;
         idx    <= '0;
         s      <= '0;
         eq     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  mode_q <= mode;
                  idx    <= '0;
                  s      <= '0;
                  eq     <= 1'b1;
               end
            end
            RUN: begin
               s <= (s & ~lane_mask) | (lane_bit ? lane_mask : '0);
               if (xor_v) eq <= 1'b0;
               // Index stops at the last lane instead of wrapping past it.
               if (!last_lane) idx <= idx + 1'b1;
            end
            default: ;  // DONE: results held until the next accepted start
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_logic_unit.sv
// Bench for serial_logic_unit: a whole-word behavioural model checked every
// cycle, directed scenarios with hand-computed literals, randomized runs, and
// a second WIDTH=1 instance.
module tb_serial_logic_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode  = 2'b00;
   logic [7:0] a     = 8'h00;
   logic [7:0] b     = 8'h00;
   logic [7:0] s;
   logic       eq, busy, done;

   logic       start1 = 1'b0;
   logic [1:0] mode1  = 2'b00;
   logic       a1     = 1'b0;
   logic       b1     = 1'b0;
   logic       s1;
   logic       eq1, busy1, done1;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   serial_logic_unit #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .a(a), .b(b), .s(s), .eq(eq), .busy(busy), .done(done)
   );

   serial_logic_unit #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .mode(mode1),
      .a(a1), .b(b1), .s(s1), .eq(eq1), .busy(busy1), .done(done1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole-word reference function.
   function automatic logic [7:0] f(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
      case (m)
         2'b00:   return ~(x ^ y);
         2'b01:   return x ^ y;
         2'b10:   return ~(x | y);
         default: return ~(x & y);
      endcase
   endfunction

   // Behavioural model: after k lanes, s is the low k bits of the full-word
   // result and eq compares the low k bits of the latched operands.
   typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
   mphase_t    ph    = M_IDLE;
   int         lanes = 0;
   logic [7:0] la, lb, full, mask;
   logic [7:0] m_s   = 8'h00;
   logic       m_eq  = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         ph = M_IDLE; m_s = 8'h00; m_eq = 1'b0; lanes = 0;
      end else begin
         case (ph)
            M_IDLE: if (start) begin
               la = a; lb = b; full = f(mode, a, b);
               m_s = 8'h00; m_eq = 1'b1; lanes = 0; ph = M_RUN;
            end
            M_RUN: begin
               lanes++;
               mask = 8'((32'd1 << lanes) - 1);
               m_s  = full & mask;
               m_eq = (((la ^ lb) & mask) == 8'h00);
               if (lanes == 8) ph = M_DONE;
            end
            default: ph = M_IDLE;
         endcase
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         check("s",    32'(s),    32'(m_s));
         check("eq",   32'(eq),   32'(m_eq));
         check("busy", 32'(busy), 32'(ph == M_RUN));
         check("done", 32'(done), 32'(ph == M_DONE));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check("done_wait", 32'(done), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || done) && n < 40) begin
         tick();
         n++;
      end
      check("idle_wait", 32'(busy | done), 32'd0);
   endtask

   logic [7:0] exp_tbl [4];

   initial begin
      exp_tbl = '{8'hC3, 8'h3C, 8'h03, 8'h3F};

      // Reset, then three idle cycles.
      reset = 1'b1;
      tick();
      tick();
      check_en = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_s",    32'(s),    32'h00);
         check("idle_eq",   32'(eq),   32'd0);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_done", 32'(done), 32'd0);
      end
      check("w1_reset_s", 32'(s1), 32'd0);

      // F0 op CC in all four modes.
      for (int m = 0; m < 4; m++) begin
         check("model_f", 32'(f(2'(m), 8'hF0, 8'hCC)), 32'(exp_tbl[m]));
         a = 8'hF0; b = 8'hCC; mode = 2'(m); start = 1'b1;
         tick();
         start = 1'b0;
         wait_done();
         check("mode_s",  32'(s),  32'(exp_tbl[m]));
         check("mode_eq", 32'(eq), 32'd0);
         tick();
      end

      // Equal operands: busy exactly 8 cycles, done 1 cycle, result held.
      begin
         int cnt = 0;
         a = 8'hA5; b = 8'hA5; mode = 2'b00; start = 1'b1;
         tick();
         start = 1'b0;
         while (busy && cnt < 20) begin
            cnt++;
            tick();
         end
         check("busy_len", 32'(cnt),  32'd8);
         check("eq_done",  32'(done), 32'd1);
         check("eq_s",     32'(s),    32'hFF);
         check("eq_flag",  32'(eq),   32'd1);
         tick();
         check("done_len", 32'(done), 32'd0);
         for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_s",  32'(s),  32'hFF);
            check("hold_eq", 32'(eq), 32'd1);
         end
      end

      // start held high; operands and mode churn every cycle.
      start = 1'b1;
      for (int i = 0; i < 80; i++) begin
         a    = 8'($urandom);
         b    = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
         mode = 2'($urandom);
         tick();
      end
      start = 1'b0;
      wait_idle();

      // Reset in the 4th RUN cycle, coinciding with a start.
      a = 8'h96; b = 8'h3C; mode = 2'b01; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1; start = 1'b1;
      tick();
      check("rst_s",    32'(s),    32'h00);
      check("rst_eq",   32'(eq),   32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset = 1'b0; start = 1'b0;
      tick();
      check("start_discard", 32'(busy), 32'd0);
      a = 8'h5A; b = 8'h0F; mode = 2'b11; start = 1'b1;
      tick();
      start = 1'b0;
      check("post_rst_busy", 32'(busy), 32'd1);
      wait_done();
      check("post_rst_s",  32'(s),  32'hF5);
      check("post_rst_eq", 32'(eq), 32'd0);
      tick();

      // WIDTH=1 instance: a=1, b=0, XOR.
      a1 = 1'b1; b1 = 1'b0; mode1 = 2'b01; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("w1_busy",   32'(busy1), 32'd1);
      check("w1_done0",  32'(done1), 32'd0);
      tick();
      check("w1_busy_end", 32'(busy1), 32'd0);
      check("w1_done",   32'(done1), 32'd1);
      check("w1_s",      32'(s1),    32'd1);
      check("w1_eq",     32'(eq1),   32'd0);
      tick();
      check("w1_done_end", 32'(done1), 32'd0);
      check("w1_hold_s",   32'(s1),    32'd1);

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
